uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 58 +++++
 rtl/uart_rx_param_if.sv | 40 ++++
 rtl/uart_sync2.sv | 31 +++
 rtl/uart_rx_param.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parameterised UART receiver:
//   - receiver FSM state encoding (rx_state_t)
//   - parity-mode constants (PAR_NONE / PAR_EVEN / PAR_ODD)
//   - minimum usable bit period
//   - small combinational helpers (parity check, 3-input majority)
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Shortest bit period the sampler can handle (three-sample window + margin).
    localparam int unsigned MIN_CPB = 4;

    // Mode 3 is reserved and behaves like "no parity".
    function automatic logic parity_enabled(input logic [1:0] mode);
        logic en;
        case (mode)
            PAR_EVEN: en = 1'b1;
            PAR_ODD:  en = 1'b1;
            default:  en = 1'b0;
        endcase
        return en;
    endfunction

    // data_xor is the XOR of all received data bits.
    function automatic logic parity_error(input logic [1:0] mode,
                                          input logic       data_xor,
                                          input logic       par_bit);
        logic sum;
        logic err;
        sum = data_xor ^ par_bit;
        case (mode)
            PAR_EVEN: err = sum;
            PAR_ODD:  err = ~sum;
            default:  err = 1'b0;
        endcase
        return err;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// -----------------------------------------------------------------------------
// uart_rx_param_if
// Receive-side result bus of the UART receiver.
//   o_RX_DV       one-cycle pulse, frame complete
//   o_RX_Data     received word (DATA_BITS wide)
//   o_Parity_Err  parity error of last frame
//   o_Frame_Err   stop-bit error of last frame
//   o_Break       last frame was a break
//   o_Busy        receiver not idle
// modport master : driven by the receiver
// modport slave  : consumer of received words
// -----------------------------------------------------------------------------
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 o_RX_DV;
    logic [DATA_BITS-1:0] o_RX_Data;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;
    logic                 o_Busy;

    modport master (
        output o_RX_DV,
        output o_RX_Data,
        output o_Parity_Err,
        output o_Frame_Err,
        output o_Break,
        output o_Busy
    );

    modport slave (
        input o_RX_DV,
        input o_RX_Data,
        input o_Parity_Err,
        input o_Frame_Err,
        input o_Break,
        input o_Busy
    );
endinterface

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// 1-bit two-flop synchroniser for the asynchronous serial line.
// Resets to 1 so a reset never looks like a start bit.
//   i_Clock  clock
//   i_Reset  synchronous active-high reset
//   i_D      asynchronous input
//   o_Q      synchronised output
// -----------------------------------------------------------------------------
module uart_sync2 (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_D,
    output logic o_Q
);
    logic r_meta;
    logic r_sync;

    // Two-stage capture of the raw line.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;
endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parameterised UART receiver: start detect with false-start rejection,
// DATA_BITS data bits LSB first, optional even/odd parity, one or two stop
// bits, break detection.
//   Parameters: DATA_BITS (5..9), CNT_W (bit-period counter width)
//   i_Clock         clock, rising edge
//   i_Reset         synchronous active-high reset
//   i_Clks_Per_Bit  clocks per bit (values below 4 act as 4)
//   i_Parity_Mode   0 none, 1 even, 2 odd, 3 none
//   i_Two_Stop      expect two stop bits
//   i_RX_Serial     asynchronous serial line, idle high
//   rx_bus          result bus (uart_rx_param_if.master)
// Build option: define UART_RX_MAJORITY_EN to take each sample as the majority
// of the synchronised line over the three cycles ending at the sample point.
// -----------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 16
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic [CNT_W-1:0] i_Clks_Per_Bit,
    input  logic [1:0]       i_Parity_Mode,
    input  logic             i_Two_Stop,
    input  logic             i_RX_Serial,
    uart_rx_param_if.master  rx_bus
);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    logic                 w_sync;
    logic                 w_bit;
    logic [CNT_W-1:0]     w_cpb_eff;
    logic [CNT_W-1:0]     w_last;
    logic [CNT_W-1:0]     w_half;
    logic                 w_sample;

    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_cpb;
    logic [1:0]           r_par_mode;
    logic                 r_two;
    logic [BIT_W-1:0]     r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_all_zero;
    logic                 r_perr_acc;
    logic                 r_ferr_acc;

    logic                 r_dv;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_break;
    logic                 r_busy;

    uart_sync2 u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_D     (i_RX_Serial),
        .o_Q     (w_sync)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Last two synchronised line values; with the current one they form the vote window.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_sync};
        end
    end

    assign w_bit = majority3(r_hist[1], r_hist[0], w_sync);
`else
    assign w_bit = w_sync;
`endif

    assign w_cpb_eff = (i_Clks_Per_Bit < CNT_W'(MIN_CPB)) ? CNT_W'(MIN_CPB) : i_Clks_Per_Bit;
    assign w_last    = r_cpb - {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_half    = w_last >> 1;
    // Counter restarts at 0 after each sample, so reaching CPB-1 means CPB clocks elapsed.
    assign w_sample  = (r_cnt == w_last);

    // Receiver FSM with registered result outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_cpb      <= CNT_W'(MIN_CPB);
            r_par_mode <= PAR_NONE;
            r_two      <= 1'b0;
            r_bit_idx  <= {BIT_W{1'b0}};
            r_stop_idx <= 1'b0;
            r_shift    <= {DATA_BITS{1'b0}};
            r_par_acc  <= 1'b0;
            r_all_zero <= 1'b1;
            r_perr_acc <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_dv       <= 1'b0;
            r_data     <= {DATA_BITS{1'b0}};
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_break    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= {CNT_W{1'b0}};
                    if (!w_sync) begin
                        // Configuration is frozen for the whole frame.
                        r_cpb      <= w_cpb_eff;
                        r_par_mode <= i_Parity_Mode;
                        r_two      <= i_Two_Stop;
                        r_state    <= ST_START;
                        r_busy     <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end

                ST_START: begin
                    if (r_cnt == w_half) begin
                        r_cnt <= {CNT_W{1'b0}};
                        if (!w_bit) begin
                            r_state    <= ST_DATA;
                            r_bit_idx  <= {BIT_W{1'b0}};
                            r_stop_idx <= 1'b0;
                            r_par_acc  <= 1'b0;
                            r_all_zero <= 1'b1;
                            r_perr_acc <= 1'b0;
                            r_ferr_acc <= 1'b0;
                        end else begin
                            // Line went back high: glitch, not a start bit.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end

                ST_DATA: begin
                    if (w_sample) begin
                        r_cnt      <= {CNT_W{1'b0}};
                        r_shift    <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_par_acc  <= r_par_acc ^ w_bit;
                        r_all_zero <= r_all_zero & ~w_bit;
                        r_bit_idx  <= r_bit_idx + {{(BIT_W-1){1'b0}}, 1'b1};
                        if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            r_state <= parity_enabled(r_par_mode) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end

                ST_PARITY: begin
                    if (w_sample) begin
                        r_cnt      <= {CNT_W{1'b0}};
                        r_perr_acc <= parity_error(r_par_mode, r_par_acc, w_bit);
                        r_all_zero <= r_all_zero & ~w_bit;
                        r_state    <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end

                ST_STOP: begin
                    if (w_sample) begin
                        r_cnt <= {CNT_W{1'b0}};
                        if (!r_stop_idx && r_all_zero && !w_bit) begin
                            // Everything low through the first stop bit: break condition.
                            r_dv    <= 1'b1;
                            r_data  <= {DATA_BITS{1'b0}};
                            r_perr  <= 1'b0;
                            r_ferr  <= 1'b1;
                            r_break <= 1'b1;
                            r_state <= ST_BREAK_WAIT;
                        end else if (!r_stop_idx && r_two) begin
                            r_ferr_acc <= ~w_bit;
                            r_stop_idx <= 1'b1;
                        end else begin
                            r_dv    <= 1'b1;
                            r_data  <= r_shift;
                            r_perr  <= r_perr_acc;
                            r_ferr  <= r_ferr_acc | ~w_bit;
                            r_break <= 1'b0;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end

                ST_BREAK_WAIT: begin
                    r_cnt <= {CNT_W{1'b0}};
                    if (w_sync) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_BREAK_WAIT;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.o_RX_DV      = r_dv;
    assign rx_bus.o_RX_Data    = r_data;
    assign rx_bus.o_Parity_Err = r_perr;
    assign rx_bus.o_Frame_Err  = r_ferr;
    assign rx_bus.o_Break      = r_break;
    assign rx_bus.o_Busy       = r_busy;
endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Self-checking bench for uart_rx_param. Expected frames are pushed to exp_q
// as they are sent; a monitor collects every DV pulse into obs_q and each test
// task pops and compares them. Expected data of the glitch-at-sample-point test
// depends on UART_RX_MAJORITY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int DB = 8;
    localparam int CW = 16;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
        logic          brk;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic [CW-1:0] cpb;
    logic [1:0]    pmode;
    logic          two;
    int            bit_cyc;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    uart_rx_param_if #(.DATA_BITS(DB)) bus ();

    uart_rx_param #(.DATA_BITS(DB), .CNT_W(CW)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Clks_Per_Bit (cpb),
        .i_Parity_Mode  (pmode),
        .i_Two_Stop     (two),
        .i_RX_Serial    (rx),
        .rx_bus         (bus)
    );

    always #5 clk = ~clk;

    // Monitor: every DV pulse becomes one observed record.
    always @(negedge clk) begin
        if (bus.o_RX_DV === 1'b1) begin
            obs_q.push_back({bus.o_RX_Data, bus.o_Parity_Err, bus.o_Frame_Err, bus.o_Break});
        end
    end

    // Drive one frame, bit_cyc cycles per bit; glitch inverts the line for one
    // cycle index, limit (>=0) truncates the frame.
    task automatic send_frame(input logic [DB-1:0] d, input bit par_en, input logic par_bit,
                              input bit two_st, input logic stop2, input int glitch, input int limit);
        logic [15:0] bits;
        int n;
        int total;
        bits = 16'hFFFF;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < DB; i++) begin bits[n] = d[i]; n++; end
        if (par_en) begin bits[n] = par_bit; n++; end
        bits[n] = 1'b1; n++;
        if (two_st) begin bits[n] = stop2; n++; end
        total = n * bit_cyc;
        if (limit >= 0 && limit < total) total = limit;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            rx = bits[c / bit_cyc] ^ (c == glitch);
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [DB+4:0] v;
        v = {bus.o_RX_DV, bus.o_RX_Data, bus.o_Parity_Err, bus.o_Frame_Err, bus.o_Break, bus.o_Busy};
        n_cmp++;
        if (v !== '0) begin n_err++; $display("FAIL reset_in: outputs=%h expected 0", v); end
        rst = 1'b0;
        idle(5);
        v = {bus.o_RX_DV, bus.o_RX_Data, bus.o_Parity_Err, bus.o_Frame_Err, bus.o_Break, bus.o_Busy};
        n_cmp++;
        if (v !== '0) begin n_err++; $display("FAIL reset_out: outputs=%h expected 0", v); end
    endtask

    task automatic test_8n1;
        rec_t e, o;
        logic [7:0] pat [4];
        pat[0] = 8'hA5; pat[1] = 8'h00; pat[2] = 8'hFF; pat[3] = 8'h3C;
        pmode = 2'd0; two = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{data: pat[i], perr: 1'b0, ferr: 1'b0, brk: 1'b0});
            send_frame(pat[i], 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
            idle(bit_cyc);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL 8n1: no DV, expected data=%h", e.data); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL 8n1: got d=%h p=%b f=%b b=%b expected d=%h p=%b f=%b b=%b", o.data, o.perr, o.ferr, o.brk, e.data, e.perr, e.ferr, e.brk); end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL 8n1_extra_dv: %0d extra pulses, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_parity;
        rec_t e, o;
        // {mode, parity bit sent, expected error}
        logic [3:0] tbl [5];
        tbl[0] = {2'd1, 1'b0, 1'b1}; tbl[1] = {2'd1, 1'b1, 1'b0};
        tbl[2] = {2'd2, 1'b0, 1'b0}; tbl[3] = {2'd2, 1'b1, 1'b1};
        tbl[4] = {2'd3, 1'b0, 1'b0};
        two = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pmode = tbl[i][3:2];
            exp_q.push_back('{data: 8'h07, perr: tbl[i][0], ferr: 1'b0, brk: 1'b0});
            send_frame(8'h07, (tbl[i][3:2] != 2'd3), tbl[i][1], 1'b0, 1'b1, -1, -1);
            idle(bit_cyc);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL parity: no DV, expected perr=%b", e.perr); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL parity: got d=%h p=%b f=%b b=%b expected d=%h p=%b f=%b b=%b", o.data, o.perr, o.ferr, o.brk, e.data, e.perr, e.ferr, e.brk); end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL parity_extra_dv: %0d extra pulses, expected 0", obs_q.size()); obs_q.delete(); end
        pmode = 2'd0;
    endtask

    task automatic test_two_stop;
        rec_t e, o;
        two = 1'b1;
        exp_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b1, brk: 1'b0});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        idle(bit_cyc);
        exp_q.push_back('{data: 8'hC3, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
        idle(bit_cyc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL two_stop: no DV, expected data=%h", e.data); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL two_stop: got d=%h p=%b f=%b b=%b expected d=%h p=%b f=%b b=%b", o.data, o.perr, o.ferr, o.brk, e.data, e.perr, e.ferr, e.brk); end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL two_stop_extra_dv: %0d extra pulses, expected 0", obs_q.size()); obs_q.delete(); end
        two = 1'b0;
    endtask

    task automatic test_glitch;
        bit low_seen;
        bit busy_seen;
        low_seen = 1'b0;
        busy_seen = 1'b0;
        repeat (3) begin @(negedge clk); rx = 1'b0; end
        @(negedge clk); rx = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_Busy === 1'b1) busy_seen = 1'b1;
            if (busy_seen && bus.o_Busy === 1'b0) low_seen = 1'b1;
        end
        n_cmp++;
        if (!low_seen) begin n_err++; $display("FAIL glitch_busy: busy=%b seen_high=%b, expected return to 0 within 10 cycles", bus.o_Busy, busy_seen); end
        idle(3 * bit_cyc);
        n_cmp++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL glitch_dv: %0d DV pulses, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_break;
        rec_t e, o;
        exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
        for (int c = 0; c < 20 * bit_cyc; c++) begin @(negedge clk); rx = 1'b0; end
        n_cmp++;
        if (bus.o_Busy !== 1'b1) begin n_err++; $display("FAIL break_wait_busy: busy=%b expected 1", bus.o_Busy); end
        @(negedge clk); rx = 1'b1;
        idle(3 * bit_cyc);
        n_cmp++;
        if (obs_q.size() != 1) begin n_err++; $display("FAIL break_dv_count: %0d DV pulses, expected 1", obs_q.size()); end
        n_cmp++;
        if (bus.o_Busy !== 1'b0) begin n_err++; $display("FAIL break_idle: busy=%b expected 0", bus.o_Busy); end
        exp_q.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(bit_cyc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL break: no DV, expected d=%h b=%b", e.data, e.brk); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL break: got d=%h p=%b f=%b b=%b expected d=%h p=%b f=%b b=%b", o.data, o.perr, o.ferr, o.brk, e.data, e.perr, e.ferr, e.brk); end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL break_extra_dv: %0d extra pulses, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid;
        rec_t e, o;
        logic [DB+4:0] v;
        // Start bit plus four data bits of 0x55, then reset.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5 * bit_cyc);
        rst = 1'b1;
        idle(3);
        v = {bus.o_RX_DV, bus.o_RX_Data, bus.o_Parity_Err, bus.o_Frame_Err, bus.o_Break, bus.o_Busy};
        n_cmp++;
        if (v !== '0) begin n_err++; $display("FAIL reset_mid_outputs: outputs=%h expected 0", v); end
        rst = 1'b0;
        idle(8 * bit_cyc);
        n_cmp++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL reset_mid_dv: %0d DV pulses, expected 0", obs_q.size()); obs_q.delete(); end
        exp_q.push_back('{data: 8'h12, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(bit_cyc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL reset_mid_next: no DV, expected data=%h", e.data); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL reset_mid_next: got d=%h p=%b f=%b b=%b expected d=%h", o.data, o.perr, o.ferr, o.brk, e.data); end
            end
        end
    endtask

    task automatic test_min_cpb;
        rec_t e, o;
        // Requested period 2 is clamped to 4 clocks per bit.
        cpb = 16'd2;
        bit_cyc = 4;
        exp_q.push_back('{data: 8'h96, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(4 * bit_cyc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL min_cpb: no DV, expected data=%h", e.data); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL min_cpb: got d=%h p=%b f=%b b=%b expected d=%h", o.data, o.perr, o.ferr, o.brk, e.data); end
            end
        end
        cpb = 16'd16;
        bit_cyc = 16;
    endtask

    task automatic test_sample_glitch;
        rec_t e, o;
        logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
        exp_d = 8'hF0;
`else
        exp_d = 8'hE0;
`endif
        // Raw cycle 88 is the one the DUT samples for data bit 4 at 16 clocks/bit.
        exp_q.push_back('{data: exp_d, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 88, -1);
        idle(bit_cyc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_err++; $display("FAIL sample_glitch: no DV, expected data=%h", e.data); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL sample_glitch: got d=%h p=%b f=%b b=%b expected d=%h", o.data, o.perr, o.ferr, o.brk, e.data); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        cpb = 16'd16;
        pmode = 2'd0;
        two = 1'b0;
        bit_cyc = 16;
        idle(4);
        test_reset;
        test_8n1;
        test_parity;
        test_two_stop;
        test_glitch;
        test_break;
        test_reset_mid;
        test_min_cpb;
        test_sample_glitch;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
